// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
//            Optional macro MDU_FAST_MULT_EN: single-cycle multiplies.
// Revision : 1.0
// ============================================================================
module mul_div_unit (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        MTHI,
   input  logic        MTLO,
   input  logic [31:0] WData,
   input  logic        ReadHiLo,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic        Busy,
   output logic        Stall
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [4:0] c_lastStep = 5'd31;

   state_t      r_state;
   logic [4:0]  r_count;
   logic [31:0] r_accHi;
   logic [31:0] r_accLo;
   logic [31:0] r_operand;
   logic        r_isDiv;
   logic        r_negQ;
   logic        r_negR;
   logic        r_divZero;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_signedOp;
   logic [31:0] w_absA;
   logic [31:0] w_absB;
   logic [32:0] w_sum;
   logic [32:0] w_shiftR;
   logic [32:0] w_diff;
   logic [63:0] w_prod;
   logic [63:0] w_prodFix;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_signedOp = ~Op[0];
   assign w_absA     = (w_signedOp && A[31]) ? -A : A;
   assign w_absB     = (w_signedOp && B[31]) ? -B : B;

   // Multiply step adds the multiplicand into the upper half; divide step
   // trial-subtracts the divisor from the partial remainder shifted left.
   assign w_sum      = {1'b0, r_accHi} + {1'b0, r_operand};
   assign w_shiftR   = {r_accHi, r_accLo[31]};
   assign w_diff     = w_shiftR - {1'b0, r_operand};

   assign w_prod     = {r_accHi, r_accLo};
   assign w_prodFix  = r_negQ ? -w_prod : w_prod;
   assign w_quot     = r_divZero ? 32'hFFFF_FFFF : (r_negQ ? -r_accLo : r_accLo);
   assign w_rem      = r_negR ? -r_accHi : r_accHi;

`ifdef MDU_FAST_MULT_EN
   logic [63:0] w_fastProd;
   assign w_fastProd = Op[0] ? ({32'b0, A} * {32'b0, B})
                             : ($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
`endif

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state   <= IDLE;
         r_count   <= 5'd0;
         r_accHi   <= 32'd0;
         r_accLo   <= 32'd0;
         r_operand <= 32'd0;
         r_isDiv   <= 1'b0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
         r_divZero <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Start) begin
`ifdef MDU_FAST_MULT_EN
                  if (!Op[1]) begin
                     {r_hi, r_lo} <= w_fastProd;
                  end else
`endif
                  begin
                     r_count   <= 5'd0;
                     r_isDiv   <= Op[1];
                     r_negQ    <= w_signedOp & (A[31] ^ B[31]);
                     r_negR    <= w_signedOp & A[31];
                     r_divZero <= Op[1] & (B == 32'd0);
                     r_accHi   <= 32'd0;
                     // Dividend or multiplier sits in the low half and is shifted out.
                     r_accLo   <= Op[1] ? w_absA : w_absB;
                     r_operand <= Op[1] ? w_absB : w_absA;
                     r_state   <= RUN;
                  end
               end else begin
                  if (MTHI) r_hi <= WData;
                  if (MTLO) r_lo <= WData;
               end
            end
            RUN: begin
               if (r_isDiv) begin
                  if (!w_diff[32]) begin
                     r_accHi <= w_diff[31:0];
                     r_accLo <= {r_accLo[30:0], 1'b1};
                  end else begin
                     r_accHi <= w_shiftR[31:0];
                     r_accLo <= {r_accLo[30:0], 1'b0};
                  end
               end else if (r_accLo[0]) begin
                  {r_accHi, r_accLo} <= {w_sum, r_accLo[31:1]};
               end else begin
                  {r_accHi, r_accLo} <= {1'b0, r_accHi, r_accLo[31:1]};
               end
               r_count <= r_count + 5'd1;
               if (r_count == c_lastStep) r_state <= FIX;
            end
            FIX: begin
               if (r_isDiv) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  {r_hi, r_lo} <= w_prodFix;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Hi    = r_hi;
   assign Lo    = r_lo;
   assign Busy  = (r_state != IDLE);
   assign Stall = Busy & (Start | ReadHiLo | MTHI | MTLO);

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit.
// Revision : 1.0
// ============================================================================
module tb_mul_div_unit;

   logic        Clock = 1'b0;
   logic        nReset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        MTHI;
   logic        MTLO;
   logic [31:0] WData;
   logic        ReadHiLo;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic        Busy;
   logic        Stall;

   int testCount = 0;
   int failCount = 0;

`ifdef MDU_FAST_MULT_EN
   localparam int c_multBusy = 0;
`else
   localparam int c_multBusy = 33;
`endif

   mul_div_unit dut (
      .Clock    (Clock),
      .nReset   (nReset),
      .Start    (Start),
      .Op       (Op),
      .A        (A),
      .B        (B),
      .MTHI     (MTHI),
      .MTLO     (MTLO),
      .WData    (WData),
      .ReadHiLo (ReadHiLo),
      .Hi       (Hi),
      .Lo       (Lo),
      .Busy     (Busy),
      .Stall    (Stall)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      assert (got === exp) else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Issue one op, count busy cycles, verify Hi/Lo never move until the result lands.
   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expHi, input logic [31:0] expLo,
                        input int expBusy, input string tag);
      logic [31:0] prevHi;
      logic [31:0] prevLo;
      logic        held;
      int          cycles;
      prevHi = Hi;
      prevLo = Lo;
      held   = 1'b1;
      cycles = 0;
      Op = op; A = a; B = b; Start = 1'b1;
      tick();
      Start = 1'b0;
      while (Busy && cycles < 40) begin
         if (Hi !== prevHi || Lo !== prevLo) held = 1'b0;
         cycles++;
         tick();
      end
      check({tag, "_busy"}, 32'(cycles), 32'(expBusy));
      check({tag, "_hi"}, Hi, expHi);
      check({tag, "_lo"}, Lo, expLo);
      if (expBusy > 0) check({tag, "_hold"}, {31'b0, held}, 32'd1);
   endtask

   initial begin
      int          cycles;
      logic [31:0] prevLo;

      nReset = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
      MTHI = 1'b0; MTLO = 1'b0; WData = '0; ReadHiLo = 1'b0;
      repeat (2) tick();
      check("rst_hi", Hi, 32'h0);
      check("rst_lo", Lo, 32'h0);
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_stall", {31'b0, Stall}, 32'd0);
      nReset = 1'b1;
      tick();

      // Move-to writes in idle
      MTHI = 1'b1; MTLO = 1'b1; WData = 32'hAAAA_5555;
      tick();
      MTHI = 1'b0; MTLO = 1'b0;
      check("mt_both_hi", Hi, 32'hAAAA_5555);
      check("mt_both_lo", Lo, 32'hAAAA_5555);
      MTLO = 1'b1; WData = 32'h0000_1234;
      tick();
      MTLO = 1'b0;
      check("mtlo_hi", Hi, 32'hAAAA_5555);
      check("mtlo_lo", Lo, 32'h0000_1234);

      // Idle with ReadHiLo must not stall
      ReadHiLo = 1'b1;
      #1;
      check("idle_nostall", {31'b0, Stall}, 32'd0);
      ReadHiLo = 1'b0;

      runOp(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, c_multBusy, "mult_m2x3");
      runOp(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, c_multBusy, "mult_m3xm5");
      runOp(2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, c_multBusy, "multu_carry");
      runOp(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7d2");
      runOp(2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 33, "divu_7d2");
      runOp(2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 33, "divu_by0");
      runOp(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 33, "div_neg_by0");
      runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div_ovf");

      // Start together with MTHI: the MT write is dropped
      MTHI = 1'b1; WData = 32'h5555_5555;
      runOp(2'b11, 32'h0000_0006, 32'h0000_0004, 32'h0000_0002, 32'h0000_0001, 33, "start_vs_mthi");
      MTHI = 1'b0;

      // Hazards while busy: ReadHiLo, MTLO, then a held second Start
      Op = 2'b11; A = 32'd100; B = 32'd7; Start = 1'b1;
      tick();
      Start = 1'b0;
      prevLo = Lo;
      ReadHiLo = 1'b1;
      #1;
      check("stall_read", {31'b0, Stall}, 32'd1);
      tick();
      ReadHiLo = 1'b0; MTLO = 1'b1; WData = 32'h0000_DEAD;
      #1;
      check("stall_mtlo", {31'b0, Stall}, 32'd1);
      tick();
      MTLO = 1'b0;
      check("busy_mtlo_ignored", Lo, prevLo);
      Op = 2'b11; A = 32'd9; B = 32'd4; Start = 1'b1;
      #1;
      check("stall_start", {31'b0, Stall}, 32'd1);
      cycles = 0;
      while (Busy && cycles < 40) begin
         cycles++;
         tick();
      end
      check("first_wait", 32'(cycles), 32'd31);
      check("first_hi", Hi, 32'd2);
      check("first_lo", Lo, 32'd14);
      check("reissue_nostall", {31'b0, Stall}, 32'd0);
      tick();
      Start = 1'b0;
      check("second_busy", {31'b0, Busy}, 32'd1);
      cycles = 0;
      while (Busy && cycles < 40) begin
         cycles++;
         tick();
      end
      check("second_wait", 32'(cycles), 32'd33);
      check("second_hi", Hi, 32'd1);
      check("second_lo", Lo, 32'd2);

      // Reset in the middle of a divide
      Op = 2'b10; A = 32'd100; B = 32'd3; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (9) tick();
      nReset = 1'b0;
      #1;
      check("midrst_hi", Hi, 32'h0);
      check("midrst_lo", Lo, 32'h0);
      check("midrst_busy", {31'b0, Busy}, 32'd0);
      check("midrst_stall", {31'b0, Stall}, 32'd0);
      #2;
      nReset = 1'b1;
      tick();
      runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, c_multBusy, "multu_after_rst");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
`default_nettype wire
